// File: rtl/cl_axil_mstr.sv
// Single-outstanding AXI4-Lite master: turns a command/response request port into
// one AW+W/B or AR/R transaction at a time, with a per-transaction abort timeout.
module cl_axil_mstr #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    // command / response port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    // AXI4-Lite master
    output logic        m_awvalid,
    output logic [31:0] m_awaddr,
    input  logic        m_awready,
    output logic        m_wvalid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_wready,
    input  logic        m_bvalid,
    input  logic [1:0]  m_bresp,
    output logic        m_bready,
    output logic        m_arvalid,
    output logic [31:0] m_araddr,
    input  logic        m_arready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t      state, state_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awvalid_q, awvalid_n;
    logic        wvalid_q, wvalid_n;
    logic        arvalid_q, arvalid_n;
    logic        bready_q, bready_n;
    logic        rready_q, rready_n;
    logic [31:0] rdata_q, rdata_n;
    logic [1:0]  resp_q, resp_n;
    logic        tmo_q, tmo_n;
    logic [15:0] cnt_q, cnt_n;
    logic        aw_left, w_left;
    logic        active, done;
    logic        timeout_hit;

    assign timeout_hit = (TIMEOUT_CYC != 16'd0) && (cnt_q == TIMEOUT_CYC);

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awvalid_n = awvalid_q;
        wvalid_n  = wvalid_q;
        arvalid_n = arvalid_q;
        bready_n  = bready_q;
        rready_n  = rready_q;
        rdata_n   = rdata_q;
        resp_n    = resp_q;
        tmo_n     = tmo_q;
        cnt_n     = cnt_q;
        aw_left   = 1'b0;
        w_left    = 1'b0;
        active    = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_n  = cmd_addr;
                    wdata_n = cmd_wdata;
                    wstrb_n = cmd_wstrb;
                    cnt_n   = 16'd0;
                    if (cmd_wr) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_REQ;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                active    = 1'b1;
                cnt_n     = cnt_q + 16'd1;
                // AW and W retire independently, in either order or together
                aw_left   = awvalid_q && !m_awready;
                w_left    = wvalid_q && !m_wready;
                awvalid_n = aw_left;
                wvalid_n  = w_left;
                if (!aw_left && !w_left) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                active = 1'b1;
                cnt_n  = cnt_q + 16'd1;
                if (m_bvalid) begin
                    done     = 1'b1;
                    bready_n = 1'b0;
                    resp_n   = m_bresp;
                    rdata_n  = 32'd0;
                    state_n  = RSP;
                end
            end
            RD_REQ: begin
                active = 1'b1;
                cnt_n  = cnt_q + 16'd1;
                if (m_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_RESP;
                end
            end
            RD_RESP: begin
                active = 1'b1;
                cnt_n  = cnt_q + 16'd1;
                if (m_rvalid) begin
                    done     = 1'b1;
                    rready_n = 1'b0;
                    rdata_n  = m_rdata;
                    resp_n   = m_rresp;
                    state_n  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                    tmo_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Only a B/R handshake finishes the transaction, so only it beats the abort
        if (active && timeout_hit && !done) begin
            awvalid_n = 1'b0;
            wvalid_n  = 1'b0;
            arvalid_n = 1'b0;
            bready_n  = 1'b0;
            rready_n  = 1'b0;
            rdata_n   = 32'd0;
            resp_n    = 2'b11;
            tmo_n     = 1'b1;
            state_n   = RSP;
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            arvalid_q <= arvalid_n;
            bready_q  <= bready_n;
            rready_q  <= rready_n;
            rdata_q   <= rdata_n;
            resp_q    <= resp_n;
            tmo_q     <= tmo_n;
            cnt_q     <= cnt_n;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RSP);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = tmo_q;

    assign m_awvalid = awvalid_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = addr_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_cl_axil_mstr.sv
// Bench for cl_axil_mstr: a configurable-delay AXI-Lite slave and a latency/response
// model derived from command-to-completion cycle arithmetic.
module tb_cl_axil_mstr;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0, m_bready, m_arvalid, m_arready = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic        m_rvalid = 1'b0, m_rready;
    logic [31:0] m_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cl_axil_mstr #(.TIMEOUT_CYC(16'(T))) dut (
        .clk_main_a0(clk), .rst_main(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One full transaction. Slave asserts each ready/valid after the given number of
    // cycles of seeing the master's valid/ready. Completion lands k cycles after the
    // command cycle (counter value k); k > T means abort, else a normal response.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int aw_d, input int w_d,
                          input int b_d, input int ar_d, input int r_d,
                          input logic [1:0] sresp, input logic [31:0] srdata,
                          input int hold, input string nm);
        int k, exp_lat, lat, awc, wc, bc, arc, rc;
        bit to, aw_hs, w_hs, ar_hs;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        k = wr ? 1 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 1 + ar_d + r_d;
        to = (T != 0) && (k > T);
        exp_lat   = to ? T + 2 : k + 2;
        exp_rdata = (wr || to) ? 32'd0 : srdata;
        exp_resp  = to ? 2'b11 : sresp;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0;

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready_idle got=%b want=1", nm, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat <= T + 5) begin
            if (lat == 1) begin
                checks++;
                if ({m_awvalid, m_wvalid, m_arvalid} !== (wr ? 3'b110 : 3'b001)) begin
                    errors++;
                    $display("FAIL %s first_valids got=%b want=%b", nm,
                             {m_awvalid, m_wvalid, m_arvalid}, wr ? 3'b110 : 3'b001);
                end
            end
            if (m_awvalid) begin
                checks++;
                if (m_awaddr !== addr || m_wdata !== wdata || m_wstrb !== wstrb) begin
                    errors++;
                    $display("FAIL %s aw_w_payload got=%h/%h/%h want=%h/%h/%h", nm,
                             m_awaddr, m_wdata, m_wstrb, addr, wdata, wstrb);
                end
            end
            if (m_arvalid) begin
                checks++;
                if (m_araddr !== addr) begin
                    errors++; $display("FAIL %s araddr got=%h want=%h", nm, m_araddr, addr);
                end
            end
            if (aw_hs || w_hs || ar_hs) begin
                checks++;
                if ((aw_hs && m_awvalid) || (w_hs && m_wvalid) || (ar_hs && m_arvalid)) begin
                    errors++;
                    $display("FAIL %s valid_after_hs got aw=%b w=%b ar=%b want=0", nm,
                             m_awvalid, m_wvalid, m_arvalid);
                end
            end
            if (m_bready || m_rready) begin
                checks++;
                if (m_bready ? !(aw_hs && w_hs) : !ar_hs) begin
                    errors++;
                    $display("FAIL %s resp_ready_early got bready=%b rready=%b want=0", nm,
                             m_bready, m_rready);
                end
            end
            m_awready = m_awvalid && (awc >= aw_d);
            if (m_awvalid && m_awready) aw_hs = 1;
            awc = m_awvalid ? awc + 1 : 0;
            m_wready = m_wvalid && (wc >= w_d);
            if (m_wvalid && m_wready) w_hs = 1;
            wc = m_wvalid ? wc + 1 : 0;
            m_arready = m_arvalid && (arc >= ar_d);
            if (m_arvalid && m_arready) ar_hs = 1;
            arc = m_arvalid ? arc + 1 : 0;
            m_bvalid = m_bready && (bc >= b_d);
            m_bresp  = m_bvalid ? sresp : 2'b00;
            bc = m_bready ? bc + 1 : 0;
            m_rvalid = m_rready && (rc >= r_d);
            m_rdata  = m_rvalid ? srdata : 32'd0;
            m_rresp  = m_rvalid ? sresp : 2'b00;
            rc = m_rready ? rc + 1 : 0;
            @(negedge clk);
            lat++;
        end
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;

        checks++;
        if (!rsp_valid) begin
            errors++; $display("FAIL %s rsp_wait got=no_rsp want=rsp_by_%0d", nm, exp_lat);
        end else if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, exp_lat);
        end
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
            errors++;
            $display("FAIL %s m_idle_in_rsp got=%b want=0", nm,
                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_resp !== exp_resp ||
                rsp_timeout !== to || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s rsp_hold[%0d] got v=%b d=%h r=%b t=%b cr=%b want v=1 d=%h r=%b t=%b cr=0",
                         nm, i, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready,
                         exp_rdata, exp_resp, to);
            end
            if (i < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s after_rsp got v=%b cr=%b t=%b want v=0 cr=1 t=0", nm,
                     rsp_valid, cmd_ready, rsp_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got cr=%b rv=%b m=%b want cr=1 rv=0 m=0", cmd_ready,
                     rsp_valid, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
        checks++;
        if (m_awaddr !== 32'd0 || m_araddr !== 32'd0 || m_wdata !== 32'd0 || m_wstrb !== 4'd0 ||
            rsp_rdata !== 32'd0 || rsp_resp !== 2'd0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h %h %b %b want all 0", m_awaddr, m_araddr,
                     m_wdata, m_wstrb, rsp_rdata, rsp_resp, rsp_timeout);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        do_txn(1, 32'h0000_0500, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, "wr_basic");
    endtask

    task automatic test_read_wait();
        do_txn(0, 32'h0000_0504, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b10, 32'h1234_5678, 0, "rd_wait");
    endtask

    task automatic test_write_skew();
        do_txn(1, 32'h0000_0A08, 32'hCAFE_F00D, 4'h5, 3, 7, 1, 0, 0, 2'b01, 32'h0, 0, "wr_skew");
        do_txn(1, 32'h0000_0A0C, 32'h0BAD_F00D, 4'h3, 6, 2, 0, 0, 0, 2'b00, 32'h0, 0, "wr_skew_rev");
    endtask

    task automatic test_timeout();
        do_txn(0, 32'h0000_0600, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 32'h5555_AAAA, 0, "to_ar");
        do_txn(0, 32'h0000_0604, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_0001, 0, "after_to");
        do_txn(1, 32'h0000_0608, 32'h1111_2222, 4'hC, 0, 30, 0, 0, 0, 2'b00, 32'h0, 2, "to_w");
        do_txn(1, 32'h0000_060C, 32'h3333_4444, 4'h1, 2, 0, 1000, 0, 0, 2'b00, 32'h0, 0, "to_b");
    endtask

    task automatic test_timeout_boundary();
        // R lands exactly on the compare cycle (handshake wins), then one cycle late
        do_txn(0, 32'h0000_0700, 32'h0, 4'h0, 0, 0, 0, 5, 10, 2'b01, 32'h0F0F_0F0F, 0, "tb_eq");
        do_txn(0, 32'h0000_0704, 32'h0, 4'h0, 0, 0, 0, 5, 11, 2'b01, 32'hF0F0_F0F0, 0, "tb_gt");
    endtask

    task automatic test_rsp_hold();
        do_txn(0, 32'h0000_0800, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, 32'h8765_4321, 10, "rsp_hold");
    endtask

    task automatic test_back_to_back();
        do_txn(1, 32'h0000_0900, 32'h0102_0304, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, "b2b_0");
        do_txn(0, 32'h0000_0904, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h0506_0708, 0, "b2b_1");
        do_txn(1, 32'h0000_0908, 32'h090A_0B0C, 4'h8, 0, 0, 0, 0, 0, 2'b10, 32'h0, 0, "b2b_2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                   int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                   int'($urandom_range(0, 9)), 2'($urandom), $urandom,
                   int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_reset_midtxn();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_0C00;
        cmd_wdata = 32'h7777_8888; cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid} !== 2'b11) begin
            errors++; $display("FAIL rst_mid_pre got=%b want=11", {m_awvalid, m_wvalid});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0 ||
            cmd_ready !== 1'b1 || m_awaddr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_async got m=%b cr=%b addr=%h want m=0 cr=1 addr=0",
                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, cmd_ready, m_awaddr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
                {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
                errors++;
                $display("FAIL rst_mid_post[%0d] got rv=%b cr=%b m=%b want rv=0 cr=1 m=0", i,
                         rsp_valid, cmd_ready, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
            end
        end
        do_txn(0, 32'h0000_0C04, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 32'hBEEF_0001, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_write_skew();
        test_timeout();
        test_timeout_boundary();
        test_rsp_hold();
        test_back_to_back();
        test_random();
        test_reset_midtxn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
